// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: sequences a burst of pulses through a downstream pulse
// generator. It issues a start strobe with the pulse width, waits for the
// generator's end strobe, idles for the programmed gap, and repeats until the
// programmed count is reached. abort and rst_n abandon a burst without done.
//
// Build option: define PULSE_SEQ_TIMEOUT_EN to add a watchdog on WAIT_END.
// The watchdog gives up after width+TIMEOUT_SLACK cycles without end_in and
// sets a sticky err. Without the macro, err is tied low and WAIT_END waits
// indefinitely.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a configuration handshake (cfg_ready high)
// FIRE     | start_out high for this one cycle
// WAIT_END | waiting for end_in from the generator
// GAP      | counting idle cycles before the next FIRE
// DONE     | done high for this one cycle, then back to IDLE

module pulse_seq_ctrl #(
   parameter int unsigned TIMEOUT_SLACK = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_width,
   input  logic [31:0] cfg_gap,
   input  logic [15:0] cfg_count,
   input  logic        abort,
   output logic        start_out,
   output logic [31:0] width_out,
   input  logic        end_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] pulse_idx,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      FIRE,
      WAIT_END,
      GAP,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] gap_lat;
   logic [31:0] gap_cnt;
   logic [15:0] count_lat;
   logic        accept;
   logic        last_pulse;
   logic        gap_exp;
   logic        timeout;

   // cfg_ready is only high while IDLE, so a handshake can only occur there
   assign accept     = cfg_valid && cfg_ready;
   assign last_pulse = ({1'b0, pulse_idx} + 17'd1) == {1'b0, count_lat};
   assign gap_exp    = (gap_cnt <= 32'd1);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; abort overrides every non-IDLE transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (cfg_count == 16'd0) ? DONE : FIRE;
            end
         end
         FIRE: begin
            state_nxt = WAIT_END;
         end
         WAIT_END: begin
            if (end_in) begin
               if (last_pulse) begin
                  state_nxt = DONE;
               end else if (gap_lat == 32'd0) begin
                  state_nxt = FIRE;
               end else begin
                  state_nxt = GAP;
               end
            end else if (timeout) begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (gap_exp) begin
               state_nxt = FIRE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
      end
   end

   // Registered status outputs, decoded from the state being entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_out <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b0;
      end else begin
         start_out <= (state_nxt == FIRE);
         done      <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
         cfg_ready <= (state_nxt == IDLE);
      end
   end

   // Burst configuration latch and completed-pulse counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         width_out <= 32'd0;
         gap_lat   <= 32'd0;
         count_lat <= 16'd0;
         pulse_idx <= 16'd0;
      end else if (accept) begin
         width_out <= (cfg_width < 32'd2) ? 32'd2 : cfg_width;
         gap_lat   <= cfg_gap;
         count_lat <= cfg_count;
         pulse_idx <= 16'd0;
      end else if ((state == WAIT_END) && end_in && !abort) begin
         pulse_idx <= pulse_idx + 16'd1;
      end
   end

   // Gap down-counter: armed while waiting for end_in, runs down in GAP and
   // stops at zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_cnt <= 32'd0;
      end else if (state == WAIT_END) begin
         gap_cnt <= gap_lat;
      end else if ((state == GAP) && (gap_cnt != 32'd0)) begin
         gap_cnt <= gap_cnt - 32'd1;
      end
   end

`ifdef PULSE_SEQ_TIMEOUT_EN
   logic [31:0] to_cnt;
   logic [32:0] to_limit;

   // width+slack can exceed 32 bits; the load saturates at all-ones
   assign to_limit = {1'b0, width_out} + 33'(TIMEOUT_SLACK);
   assign timeout  = (state == WAIT_END) && (to_cnt == 32'd0);

   // Watchdog down-counter: loaded in FIRE, hits zero on the last tolerated
   // WAIT_END cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= 32'd0;
      end else if (state == FIRE) begin
         to_cnt <= to_limit[32] ? 32'hFFFF_FFFF : (to_limit[31:0] - 32'd1);
      end else if ((state == WAIT_END) && (to_cnt != 32'd0)) begin
         to_cnt <= to_cnt - 32'd1;
      end
   end

   // Sticky error; a late end_in or an abort in the same cycle wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (timeout && !end_in && !abort) begin
         err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl. A small generator model returns
// end_in a fixed delay after each start_out. Expected behaviour for a burst
// is computed from the burst timeline arithmetic (start, end, gap spacing).
module tb_pulse_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_width;
   logic [31:0] cfg_gap;
   logic [15:0] cfg_count;
   logic        abort;
   logic        start_out;
   logic [31:0] width_out;
   logic        end_in;
   logic        busy;
   logic        done;
   logic [15:0] pulse_idx;
   logic        err;

   pulse_seq_ctrl #(.TIMEOUT_SLACK(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_width (cfg_width),
      .cfg_gap   (cfg_gap),
      .cfg_count (cfg_count),
      .abort     (abort),
      .start_out (start_out),
      .width_out (width_out),
      .end_in    (end_in),
      .busy      (busy),
      .done      (done),
      .pulse_idx (pulse_idx),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int cyc;
   int gen_end;
   int gen_d;

   typedef struct {
      int          w;
      int          g;
      int          n;
      int          d;
      int          abk;
      logic [31:0] exp_w;
      logic [15:0] exp_idx;
      int          exp_starts;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   // Advance one clock, then play the downstream generator for this cycle
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      end_in = 1'b0;
      if (start_out && gen_d > 0) gen_end = cyc + gen_d;
      if (cyc == gen_end) end_in = 1'b1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_start"}, 32'(start_out), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_ready"}, 32'(cfg_ready), 0);
      chk({tag, "_idx"}, 32'(pulse_idx), 0);
      chk({tag, "_width"}, width_out, 0);
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (cfg_ready !== 1'b1 && k < 10) begin
         cycle();
         k++;
      end
      chk("ready_before_accept", 32'(cfg_ready), 1);
   endtask

   // One burst, checked every cycle against the timeline model.
   // abk >= 0 asserts abort together with the abk-th (0-based) end_in.
   task automatic run_burst(input int w, input int g, input int n, input int d,
                            input int abk, input bit noise, input bit ab_acc,
                            output int ns, output int nd,
                            output logic [15:0] idx_f, output logic [31:0] wo_f);
      int a, per, nst, nend, busy_end, done_cyc, ends_seen, eidx;
      bit aborted, e_start, e_busy, in_gap;
      logic [31:0] wexp;
      wait_ready();
      cfg_valid = 1'b1;
      cfg_width = 32'(w);
      cfg_gap   = 32'(g);
      cfg_count = 16'(n);
      abort     = ab_acc;
      gen_d     = d;
      a         = cyc;
      cycle();
      cfg_valid = 1'b0;
      abort     = 1'b0;
      cfg_width = $urandom;
      cfg_gap   = $urandom;
      cfg_count = 16'($urandom);
      per     = d + 1 + g;
      aborted = (abk >= 0) && (abk < n);
      nst     = aborted ? abk + 1 : n;
      nend    = aborted ? abk : n;
      wexp    = (w < 2) ? 32'd2 : 32'(w);
      if (n == 0) begin
         busy_end = a + 1;
         done_cyc = a + 1;
      end else if (aborted) begin
         busy_end = a + 1 + abk * per + d;
         done_cyc = -1;
      end else begin
         busy_end = a + 1 + (n - 1) * per + d + 1;
         done_cyc = busy_end;
      end
      ns = 0;
      nd = 0;
      ends_seen = 0;
      for (int c = a + 1; c <= busy_end + 3; c++) begin
         e_start = 0;
         eidx    = 0;
         for (int k = 0; k < nst; k++) if (c == a + 1 + k * per) e_start = 1;
         for (int k = 0; k < nend; k++) if (a + 1 + k * per + d < c) eidx++;
         e_busy = (c <= busy_end);
         chk("start_out", 32'(start_out), 32'(e_start));
         chk("done", 32'(done), 32'(c == done_cyc));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("cfg_ready", 32'(cfg_ready), 32'(!e_busy));
         chk("pulse_idx", 32'(pulse_idx), 32'(eidx));
         chk("width_out", width_out, wexp);
         chk("err", 32'(err), 0);
         ns += int'(start_out);
         nd += int'(done);
         abort = 1'b0;
         if (end_in) begin
            if (ends_seen == abk) abort = 1'b1;
            ends_seen++;
         end
         if (noise && !end_in) begin
            in_gap = (c > busy_end);
            for (int k = 0; k + 1 < nst; k++)
               if (c > a + 1 + k * per + d && c < a + 1 + (k + 1) * per) in_gap = 1;
            if (in_gap) end_in = 1'b1;
         end
         cycle();
      end
      abort = 1'b0;
      idx_f = pulse_idx;
      wo_f  = width_out;
   endtask

   initial begin
      int ns, nd, a;
      logic [15:0] idx_f;
      logic [31:0] wo_f;
      clk = 1'b0;
      rst_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_width = '0;
      cfg_gap = '0;
      cfg_count = '0;
      abort = 1'b0;
      end_in = 1'b0;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      gen_end = -1;
      gen_d = 0;

      // width, gap, count, generator delay, abort index, expectations
      vecs[0] = '{w: 5, g: 3, n: 3, d: 5, abk: -1, exp_w: 32'd5, exp_idx: 16'd3, exp_starts: 3, exp_done: 1};
      vecs[1] = '{w: 7, g: 2, n: 0, d: 3, abk: -1, exp_w: 32'd7, exp_idx: 16'd0, exp_starts: 0, exp_done: 1};
      vecs[2] = '{w: 1, g: 0, n: 2, d: 2, abk: -1, exp_w: 32'd2, exp_idx: 16'd2, exp_starts: 2, exp_done: 1};
      vecs[3] = '{w: 4, g: 2, n: 4, d: 4, abk: 1,  exp_w: 32'd4, exp_idx: 16'd1, exp_starts: 2, exp_done: 0};
      vecs[4] = '{w: 0, g: 1, n: 1, d: 2, abk: -1, exp_w: 32'd2, exp_idx: 16'd1, exp_starts: 1, exp_done: 1};

      repeat (3) cycle();
      chk_reset("reset");
      rst_n = 1'b1;
      cycle();
      chk("ready_after_release", 32'(cfg_ready), 1);

      foreach (vecs[i]) begin
         run_burst(vecs[i].w, vecs[i].g, vecs[i].n, vecs[i].d, vecs[i].abk, 1'b0, 1'b0,
                   ns, nd, idx_f, wo_f);
         chk("vec_starts", 32'(ns), 32'(vecs[i].exp_starts));
         chk("vec_done", 32'(nd), 32'(vecs[i].exp_done));
         chk("vec_idx", 32'(idx_f), 32'(vecs[i].exp_idx));
         chk("vec_width", wo_f, vecs[i].exp_w);
      end

      // abort in IDLE alongside the handshake must not block the accept
      run_burst(4, 0, 1, 3, -1, 1'b0, 1'b1, ns, nd, idx_f, wo_f);
      chk("idle_abort_starts", 32'(ns), 1);
      chk("idle_abort_done", 32'(nd), 1);

      // randomized bursts, with stray end_in outside WAIT_END on some
      for (int r = 0; r < 14; r++) begin
         int rw, rg, rn, rd, rab;
         rw  = $urandom_range(0, 9);
         rg  = $urandom_range(0, 4);
         rn  = $urandom_range(0, 4);
         rd  = $urandom_range(1, 6);
         rab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
         run_burst(rw, rg, rn, rd, rab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ns, nd, idx_f, wo_f);
      end

      // reset pulsed during GAP abandons the burst silently
      wait_ready();
      cfg_valid = 1'b1;
      cfg_width = 32'd3;
      cfg_gap = 32'd6;
      cfg_count = 16'd3;
      gen_d = 3;
      a = cyc;
      cycle();
      cfg_valid = 1'b0;
      while (cyc < a + 6) begin
         chk("pre_reset_done", 32'(done), 0);
         cycle();
      end
      chk("in_gap_busy", 32'(busy), 1);
      rst_n = 1'b0;
      cycle();
      chk_reset("mid_reset");
      rst_n = 1'b1;
      cycle();
      chk("mid_reset_ready", 32'(cfg_ready), 1);
      repeat (6) begin
         chk("post_reset_done", 32'(done), 0);
         chk("post_reset_start", 32'(start_out), 0);
         cycle();
      end
      run_burst(3, 1, 2, 3, -1, 1'b0, 1'b0, ns, nd, idx_f, wo_f);
      chk("post_reset_idx", 32'(idx_f), 2);
      chk("post_reset_ndone", 32'(nd), 1);

`ifdef PULSE_SEQ_TIMEOUT_EN
      // generator never answers: watchdog fires width+slack cycles into WAIT_END
      wait_ready();
      cfg_valid = 1'b1;
      cfg_width = 32'd10;
      cfg_gap = 32'd0;
      cfg_count = 16'd1;
      gen_d = 0;
      a = cyc;
      cycle();
      cfg_valid = 1'b0;
      for (int c = a + 1; c <= a + 31; c++) begin
         chk("to_busy", 32'(busy), 32'(c <= a + 27));
         chk("to_err", 32'(err), 32'(c >= a + 28));
         chk("to_done", 32'(done), 0);
         cycle();
      end
      run_burst(2, 0, 1, 2, -1, 1'b0, 1'b0, ns, nd, idx_f, wo_f);
      chk("err_cleared_done", 32'(nd), 1);
`else
      // generator never answers: WAIT_END holds, then abort releases it
      wait_ready();
      cfg_valid = 1'b1;
      cfg_width = 32'd2;
      cfg_gap = 32'd0;
      cfg_count = 16'd1;
      gen_d = 0;
      cycle();
      cfg_valid = 1'b0;
      repeat (40) cycle();
      chk("hang_busy", 32'(busy), 1);
      chk("hang_err", 32'(err), 0);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("hang_abort_busy", 32'(busy), 0);
      chk("hang_abort_done", 32'(done), 0);
      chk("hang_abort_idx", 32'(pulse_idx), 0);
      chk("hang_abort_ready", 32'(cfg_ready), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_seq_ctrl.md
PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SLACK, default 16: extra cycles beyond the programmed width tolerated while waiting for end_in (used only with PULSE_SEQ_TIMEOUT_EN).
REQ-002 SHALL have ports as follows, clock and reset first:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration accepted when high with cfg_valid.
- cfg_width  input  32  pulse width in cycles.
- cfg_gap  input  32  idle cycles between end_in and the next start_out.
- cfg_count  input  16  number of pulses in the burst.
- abort  input  1  terminate the burst.
- start_out  output  1  one-cycle start strobe to the downstream pulse generator.
- width_out  output  32  pulse width to the downstream generator.
- end_in  input  1  one-cycle end-of-pulse strobe from the downstream generator.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle burst-complete strobe.
- pulse_idx  output  16  pulses completed in the current burst.
- err  output  1  sticky timeout flag.

Function
REQ-003 SHALL implement the states IDLE, FIRE, WAIT_END, GAP and DONE; all outputs SHALL be registered.
REQ-004 SHALL drive cfg_ready high only in IDLE; a handshake SHALL latch width, gap and count, clear pulse_idx and err, and enter FIRE on the next cycle, or DONE when cfg_count=0.
REQ-005 SHALL clamp a latched width below 2 to 2, because the downstream generator needs at least 2 cycles.
REQ-006 SHALL assert start_out for exactly one cycle, in FIRE, then move to WAIT_END; start_out SHALL first appear 1 cycle after the accepting handshake.
REQ-007 SHALL hold width_out at the latched width from FIRE until the burst ends.
REQ-008 In WAIT_END, on end_in, SHALL increment pulse_idx (16-bit, no wrap needed since count ≤ 65535), then go:
- to DONE if pulse_idx+1 equals count;
- else to FIRE if gap=0;
- else to GAP.
REQ-009 In GAP, SHALL count gap cycles, then go to FIRE, so that end_in at cycle t gives the next start_out at cycle t+1+gap.
REQ-010 SHALL ignore end_in outside WAIT_END.
REQ-011 SHALL assert done for one cycle in DONE, then return to IDLE; pulse_idx SHALL hold its final value until the next accept.
REQ-012 abort SHALL take priority over end_in and over gap expiry; from any non-IDLE state the block SHALL go to IDLE next cycle, with no start_out and no done that cycle, and pulse_idx held.
REQ-013 abort in IDLE SHALL have no effect; a simultaneous cfg handshake SHALL still be accepted.
REQ-014 SHALL keep gap and timeout counters 32 bits wide and saturating.

Reset
REQ-015 On rst_n=0 at a clock edge, SHALL go to IDLE with the following values: start_out=0, done=0, busy=0, err=0, cfg_ready=0, pulse_idx=0, width_out=0, and all counters 0.
REQ-016 cfg_ready SHALL rise the first cycle after reset release.
REQ-017 Reset mid-burst SHALL abandon the burst without a done strobe.

Configuration
REQ-018 With PULSE_SEQ_TIMEOUT_EN defined, SHALL count cycles in WAIT_END; on reaching width+TIMEOUT_SLACK without end_in, SHALL set err (sticky until the next accept or reset) and go to IDLE without done.
REQ-019 Without PULSE_SEQ_TIMEOUT_EN, the watchdog logic SHALL be absent, err SHALL be tied to 0, and WAIT_END SHALL wait indefinitely.

Verification
REQ-020 Accept width=5, gap=3, count=3, with a model generator giving end_in 5 cycles after start -> 3 start_out strobes, each end_in to next start_out spacing 4 cycles, done once, pulse_idx=3, width_out=5.
REQ-021 Accept count=0 -> done 1 cycle after accept, no start_out, pulse_idx=0.
REQ-022 Accept width=1, gap=0, count=2 -> width_out=2; each start_out 1 cycle after the previous end_in.
REQ-023 Assert abort in the same cycle as the 2nd end_in of count=4 -> IDLE next cycle, pulse_idx=1, no done, cfg_ready=1.
REQ-024 With PULSE_SEQ_TIMEOUT_EN, width=10 and end_in never returned -> err=1 exactly 26 cycles after WAIT_END entry, busy=0, no done.
REQ-025 Pulse rst_n low during GAP -> all outputs at reset values, no done; a new burst accepted afterwards runs normally.
